// File: rtl/boot_stream_pkg.sv
// boot_stream_pkg
//   Shared definitions for the boot stream unpacker slice:
//   - SYNC_BYTE_DEFAULT : default marker byte for the sync-hunt build
//   - in_state_t        : host-side handshake FSM states
//   - bytes_per_word()  : bytes carried by one boot word of a given width
package boot_stream_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h4E;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    WAITLOW = 2'd2
  } in_state_t;

  function automatic int bytes_per_word(input int word_w);
    return word_w / 8;
  endfunction

endpackage

// File: rtl/boot_stream_unpacker_if.sv
// boot_stream_unpacker_if
//   Bundles the host word handshake and the byte output handshake.
//   Ports (as seen from the slave / unpacker side):
//     in_req    in   host presents a word on in_data
//     in_data   in   boot word, byte 0 in bits [7:0]
//     in_ack    out  one-cycle accept pulse
//     out_valid out  out_data holds a byte
//     out_data  out  output byte
//     out_ready in   consumer accepts the byte
//
//   Handshakes:
//     Host side is a four-phase req/ack: the host raises in_req with in_data
//     stable, the unpacker answers with a single in_ack pulse, and the host
//     must drop in_req (keeping in_data stable through the ack cycle) before
//     the next word can be accepted.
//     Byte side is strict valid/ready: a byte transfers on every clock edge
//     where out_valid && out_ready; while out_valid is high and out_ready is
//     low, out_valid and out_data do not change.
interface boot_stream_unpacker_if #(
  parameter int WORD_W = 32
);
  logic              in_req;
  logic [WORD_W-1:0] in_data;
  logic              in_ack;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_ready;

  modport master (
    output in_req, in_data, out_ready,
    input  in_ack, out_valid, out_data
  );

  modport slave (
    input  in_req, in_data, out_ready,
    output in_ack, out_valid, out_data
  );
endinterface

// File: rtl/boot_word_fifo.sv
// boot_word_fifo
//   Single-clock synchronous word FIFO, DEPTH must be a power of two.
//   Ports:
//     clk, reset  clock and synchronous active-high reset (empties the FIFO)
//     push        write push_data (ignored when full)
//     push_data   word to write
//     pop         drop the head word (ignored when empty)
//     pop_data    current head word (valid while !empty)
//     full/empty  occupancy flags
//   Push and pop in the same cycle are both honoured.
module boot_word_fifo #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  output logic [WORD_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              push_ok;
  logic              pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/boot_stream_unpacker.sv
// boot_stream_unpacker
//   Accepts boot words from the control CPU over a req/ack handshake, buffers
//   them in a word FIFO, truncates the stream at the programmed ROM size and
//   serialises it little-endian into a valid/ready byte stream.
//   Ports:
//     clk, reset    single clock, synchronous active-high reset
//     rom_size      bytes to deliver, latched on the first accepted word
//     bus (slave)   in_req/in_data/in_ack and out_valid/out_data/out_ready
//     bytes_loaded  bytes accepted from the host, capped at the ROM size
//     done          every byte delivered or dropped; sticky until reset
//     fifo_full     FIFO full flag
//     in_state      host handshake FSM state (debug)
//   Build option: BOOT_SYNC_HUNT_EN drops bytes after reset until the first
//   byte equal to SYNC_BYTE; dropped bytes still count toward the ROM size.
module boot_stream_unpacker
  import boot_stream_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 8,
  parameter int SIZE_W = 32
`ifdef BOOT_SYNC_HUNT_EN
  ,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SIZE_W-1:0]    rom_size,
  boot_stream_unpacker_if.slave bus,
  output logic [SIZE_W-1:0]    bytes_loaded,
  output logic                 done,
  output logic                 fifo_full,
  output in_state_t            in_state
);
  localparam int BPW = bytes_per_word(WORD_W);
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BPW - 1);

  // ---------------- host side ----------------
  logic              in_ack_q;
  logic [SIZE_W-1:0] size_latched;
  logic              size_valid;
  logic [SIZE_W-1:0] remaining;
  logic [SIZE_W-1:0] load_step;
  logic              push;

  assign remaining = size_latched - bytes_loaded;
  assign load_step = (remaining >= SIZE_W'(BPW)) ? SIZE_W'(BPW) : remaining;
  // Words past the ROM size are still acked so the host never stalls on them.
  assign push      = (in_state == ACK) && (bytes_loaded < size_latched);
  assign bus.in_ack = in_ack_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_state     <= IDLE;
      in_ack_q     <= 1'b0;
      bytes_loaded <= '0;
      size_latched <= '0;
      size_valid   <= 1'b0;
    end else begin
      case (in_state)
        IDLE: begin
          // Full is checked here; nothing else pushes before the ACK cycle,
          // so the accept decision cannot be invalidated.
          if (bus.in_req && !fifo_full) begin
            in_state <= ACK;
            in_ack_q <= 1'b1;
            if (!size_valid) begin
              size_latched <= rom_size;
              size_valid   <= 1'b1;
            end
          end
        end
        ACK: begin
          in_ack_q     <= 1'b0;
          bytes_loaded <= bytes_loaded + load_step;
          in_state     <= WAITLOW;
        end
        WAITLOW: begin
          if (!bus.in_req) in_state <= IDLE;
        end
        default: begin
          in_state <= IDLE;
          in_ack_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- word FIFO ----------------
  logic [WORD_W-1:0] fifo_head;
  logic              fifo_empty;
  logic              take_word;

  boot_word_fifo #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (bus.in_data),
    .pop       (take_word),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ---------------- unpacker ----------------
  // word_reg holds the word being serialised; nxt_idx is the next byte to
  // issue from it and word_live says bytes remain. One byte slot is processed
  // per cycle whenever the output register is free; a slot beyond the ROM
  // size is consumed silently.
  logic [WORD_W-1:0] word_reg;
  logic [IW-1:0]     nxt_idx;
  logic              word_live;
  logic              out_valid_q;
  logic [7:0]        out_data_q;
  logic [SIZE_W-1:0] out_cnt;
  logic              slot_free;
  logic              issue;
  logic              in_budget;
  logic              emit;
  logic [7:0]        issue_byte;

  assign slot_free  = !out_valid_q || bus.out_ready;
  assign take_word  = slot_free && !word_live && !fifo_empty;
  assign issue      = slot_free && (word_live || !fifo_empty);
  assign issue_byte = word_live ? word_reg[{nxt_idx, 3'b000} +: 8] : fifo_head[7:0];
  assign in_budget  = (out_cnt < size_latched);

`ifdef BOOT_SYNC_HUNT_EN
  logic synced;
  assign emit = issue && in_budget && (synced || (issue_byte == SYNC_BYTE));

  always_ff @(posedge clk) begin
    if (reset)     synced <= 1'b0;
    else if (emit) synced <= 1'b1;
  end
`else
  assign emit = issue && in_budget;
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      word_reg    <= '0;
      nxt_idx     <= '0;
      word_live   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_cnt     <= '0;
      done        <= 1'b0;
    end else begin
      if (slot_free) begin
        out_valid_q <= emit;
        if (emit) out_data_q <= issue_byte;
      end
      if (issue && in_budget) out_cnt <= out_cnt + 1'b1;
      if (take_word) begin
        // Byte 0 of the popped word is issued this cycle.
        word_reg  <= fifo_head;
        nxt_idx   <= IW'(1);
        word_live <= (BPW > 1);
      end else if (slot_free && word_live) begin
        nxt_idx <= nxt_idx + 1'b1;
        if (nxt_idx == LAST_IDX) word_live <= 1'b0;
      end
      if (size_valid && (out_cnt == size_latched) && !out_valid_q) done <= 1'b1;
    end
  end
endmodule

// File: tb/tb_boot_stream_unpacker.sv
// tb_boot_stream_unpacker
//   Directed bench for boot_stream_unpacker (WORD_W=32, DEPTH=8, SIZE_W=32).
//   A stream-level model turns every acked word into the bytes that must
//   appear (capped at the ROM size, sync-filtered in the BOOT_SYNC_HUNT_EN
//   build) and one compare process checks each transferred byte against it.
module tb_boot_stream_unpacker;
  import boot_stream_pkg::*;

  localparam int WORD_W = 32;
  localparam int BPW    = WORD_W / 8;
`ifdef BOOT_SYNC_HUNT_EN
  localparam bit HUNT = 1'b1;
`else
  localparam bit HUNT = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rom_size;
  logic [31:0] bytes_loaded;
  logic        done;
  logic        fifo_full;
  in_state_t   in_state;

  always #5 clk = ~clk;

  boot_stream_unpacker_if #(.WORD_W(WORD_W)) bus ();

  boot_stream_unpacker #(.WORD_W(WORD_W), .DEPTH(8), .SIZE_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .rom_size     (rom_size),
    .bus          (bus),
    .bytes_loaded (bytes_loaded),
    .done         (done),
    .fifo_full    (fifo_full),
    .in_state     (in_state)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  out_log[$];
  int          ack_count;
  logic [31:0] m_size;
  logic [31:0] m_loaded;
  bit          m_latched;
  bit          m_synced;
  bit          stall_pending;
  logic [7:0]  stall_data;
  int          cyc = 0;
  int          first_ack_cyc;
  int          first_valid_cyc;

  logic [7:0] lit_bytes [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every accepted word contributes its bytes in order until the ROM size
  // is used up; with hunting, bytes before the first marker are swallowed.
  task automatic model_accept(input logic [WORD_W-1:0] w);
    logic [7:0] b;
    ack_count++;
    if (!m_latched) begin
      m_latched = 1'b1;
      m_size    = rom_size;
    end
    for (int k = 0; k < BPW; k++) begin
      if (m_loaded < m_size) begin
        b = w[8*k +: 8];
        m_loaded++;
        if (HUNT && !m_synced && b != 8'h4E) continue;
        m_synced = 1'b1;
        exp_q.push_back(b);
      end
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_latched       = 1'b0;
      m_synced        = 1'b0;
      m_loaded        = 0;
      m_size          = 0;
      ack_count       = 0;
      stall_pending   = 1'b0;
      first_ack_cyc   = -1;
      first_valid_cyc = -1;
    end else begin
      if (bus.in_ack) begin
        model_accept(bus.in_data);
        if (first_ack_cyc < 0) first_ack_cyc = cyc;
      end
      if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (stall_pending) begin
        check("hold_valid", bus.out_valid, 1'b1);
        check("hold_data", bus.out_data, stall_data);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h, expected no byte", bus.out_data);
        end else begin
          check("byte", bus.out_data, exp_q.pop_front());
        end
        out_log.push_back(bus.out_data);
      end
      stall_pending = bus.out_valid && !bus.out_ready;
      stall_data    = bus.out_data;
      if (done) check("done_with_pending_bytes", exp_q.size(), 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_test(input logic [31:0] size, input logic ready);
    reset         = 1'b1;
    rom_size      = size;
    bus.out_ready = ready;
    bus.in_req    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    out_log.delete();
  endtask

  task automatic req_word(input logic [WORD_W-1:0] w);
    bus.in_data = w;
    bus.in_req  = 1'b1;
  endtask

  task automatic wait_ack(input int max, output bit got);
    got = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (bus.in_ack) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // Keep in_req low across two edges so the FSM sees it while in WAITLOW.
  task automatic release_req();
    bus.in_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w);
    bit got;
    req_word(w);
    wait_ack(20, got);
    check("ack_seen", got, 1'b1);
    release_req();
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max; i++) begin
      if (done) break;
      tick();
    end
    check("done", done, 1'b1);
  endtask

  task automatic end_checks();
    check("model_drained", exp_q.size(), 0);
    check("bytes_loaded_model", bytes_loaded, m_loaded);
  endtask

  function automatic logic [31:0] mk_word(input int i);
    return {8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)};
  endfunction

  // ---------------- directed tests ----------------
  initial begin
    bit got;
    int n;
    reset       = 1'b1;
    rom_size    = 0;
    bus.in_req  = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ack", bus.in_ack, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, 8'h00);
    check("rst_bytes_loaded", bytes_loaded, 32'd0);
    check("rst_done", done, 1'b0);
    check("rst_fifo_full", fifo_full, 1'b0);
    check("rst_state", in_state, IDLE);
    reset = 1'b0;

`ifndef BOOT_SYNC_HUNT_EN
    // Two full words, ROM size 8.
    start_test(8, 1'b1);
    send_word(32'h44332211);
    send_word(32'h88776655);
    wait_done(50);
    check("t1_count", out_log.size(), 8);
    for (int i = 0; i < 8 && i < out_log.size(); i++) check("t1_lit", out_log[i], lit_bytes[i]);
    check("t1_bytes_loaded", bytes_loaded, 32'd8);
    check("t1_acks", ack_count, 2);
    check("t1_first_byte_latency", first_valid_cyc - first_ack_cyc, 2);
    end_checks();

    // ROM size 6: tail of the second word and the whole third word dropped.
    start_test(6, 1'b1);
    send_word(32'h44332211);
    send_word(32'h88776655);
    send_word(32'hCCBBAA99);
    wait_done(50);
    check("t2_count", out_log.size(), 6);
    for (int i = 0; i < 6 && i < out_log.size(); i++) check("t2_lit", out_log[i], lit_bytes[i]);
    check("t2_bytes_loaded", bytes_loaded, 32'd6);
    check("t2_acks", ack_count, 3);
    end_checks();

    // ROM size 0: done one cycle after the first ack, words acked and dropped.
    start_test(0, 1'b1);
    req_word(32'hDEADBEEF);
    wait_ack(20, got);
    check("t3_ack", got, 1'b1);
    check("t3_done_in_ack_cycle", done, 1'b0);
    tick();
    check("t3_done_after_ack", done, 1'b1);
    release_req();
    send_word(32'h01020304);
    repeat (5) tick();
    check("t3_count", out_log.size(), 0);
    check("t3_bytes_loaded", bytes_loaded, 32'd0);
    check("t3_acks", ack_count, 2);
    end_checks();

    // Back-pressure: one word in the unpacker plus eight in the FIFO.
    start_test(64, 1'b0);
    for (int i = 0; i < 9; i++) send_word(mk_word(i));
    check("t4_acks_before_stall", ack_count, 9);
    req_word(mk_word(9));
    wait_ack(20, got);
    check("t4_stalled", got, 1'b0);
    check("t4_fifo_full", fifo_full, 1'b1);
    check("t4_held_valid", bus.out_valid, 1'b1);
    check("t4_held_byte", bus.out_data, 8'h01);
    bus.out_ready = 1'b1;
    wait_ack(30, got);
    check("t4_resumed", got, 1'b1);
    release_req();
    for (int i = 10; i < 16; i++) send_word(mk_word(i));
    wait_done(200);
    n = 0;
    for (int i = 0; i < out_log.size(); i++) if (out_log[i] != 8'(i + 1)) n++;
    check("t4_count", out_log.size(), 64);
    check("t4_seq_mismatches", n, 0);
    check("t4_acks", ack_count, 16);
    check("t4_bytes_loaded", bytes_loaded, 32'd64);
    end_checks();

    // Request held high: a single ack only.
    start_test(8, 1'b1);
    req_word(32'h44332211);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.in_ack) n++;
    end
    release_req();
    check("t5_single_ack", n, 1);
    send_word(32'h88776655);
    wait_done(50);
    check("t5_count", out_log.size(), 8);
    end_checks();

    // Reset after three bytes, then a fresh transfer.
    start_test(8, 1'b0);
    send_word(32'h44332211);
    send_word(32'h88776655);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_log.size() >= 3) break;
    end
    check("t6_three_bytes", out_log.size(), 3);
    reset = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    check("t6_rst_valid", bus.out_valid, 1'b0);
    check("t6_rst_loaded", bytes_loaded, 32'd0);
    check("t6_rst_done", done, 1'b0);
    check("t6_rst_full", fifo_full, 1'b0);
    reset = 1'b0;
    out_log.delete();
    bus.out_ready = 1'b1;
    send_word(32'h44332211);
    send_word(32'h88776655);
    wait_done(50);
    check("t6_count", out_log.size(), 8);
    for (int i = 0; i < 8 && i < out_log.size(); i++) check("t6_lit", out_log[i], lit_bytes[i]);
    end_checks();
`else
    // Sync hunt: AA FF 00 dropped, marker and everything after emitted.
    start_test(8, 1'b1);
    send_word(32'h4E00FFAA);
    send_word(32'h1A53454E);
    wait_done(50);
    check("s1_count", out_log.size(), 5);
    if (out_log.size() == 5) begin
      check("s1_b0", out_log[0], 8'h4E);
      check("s1_b1", out_log[1], 8'h4E);
      check("s1_b2", out_log[2], 8'h45);
      check("s1_b3", out_log[3], 8'h53);
      check("s1_b4", out_log[4], 8'h1A);
    end
    end_checks();

    // ROM exhausted before any marker: done, nothing emitted.
    start_test(4, 1'b1);
    send_word(32'h11223344);
    wait_done(50);
    check("s2_count", out_log.size(), 0);
    check("s2_bytes_loaded", bytes_loaded, 32'd4);
    end_checks();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end
endmodule
